// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmitter:
//                transmit FSM state type, line-level constants, the default
//                bit period and a helper for sizing counters.
//                Optional feature macro: UART_TX_PARITY_EN (adds PARITY state).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter for the UART transmitter. Counts
//                0..CLKS_PER_BIT-1 while enabled and wraps to 0; held at 0
//                while disabled so every frame starts on a fresh period.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_en         - count enable (frame in progress)
//                o_count      - current position inside the bit period
//                o_bit_tick   - high on the last cycle of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = cnt_width(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_bit_tick
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_tick;

    assign w_tick = (r_count == C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_bit_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Accepts a word on a valid/ready handshake
//                and serialises it as start bit, DATA_WIDTH data bits (LSB
//                first), optional parity bit and STOP_BITS stop bits.
//                Optional feature macro: UART_TX_PARITY_EN - inserts one
//                parity bit (XOR of data ^ PARITY_ODD) after the data bits.
//  Ports       : t_clk, t_rst - clock, synchronous active-high reset
//                tx_valid     - word offered on tx_data_in
//                tx_data_in   - payload
//                tx_ready     - block is idle and can accept a word
//                tx_serial    - serial line (idles high, registered)
//                tx_busy      - frame in progress
//                tx_done      - one-cycle pulse on the last stop cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  t_clk,
    input  logic                  t_rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = cnt_width(DATA_WIDTH);

    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    // tx_done is registered, so it is raised one cycle before the final
    // stop cycle in order to be visible exactly on that cycle.
    localparam logic [CNT_W-1:0] C_CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic             C_STOP_LAST = 1'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_tx: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_stop_idx;
    logic                  r_serial;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_tick;
    logic                  w_accept;

    assign w_accept = tx_valid && r_ready;

    // Bit period runs only while a frame is active, so it restarts from 0
    // on the cycle after acceptance.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_gen (
        .clk        (t_clk),
        .rst        (t_rst),
        .i_en       (r_busy),
        .o_count    (w_cnt),
        .o_bit_tick (w_tick)
    );

    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_serial   <= LINE_IDLE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_serial <= LINE_IDLE;
                    if (w_accept) begin
                        r_shift    <= tx_data_in;
                        r_idx      <= '0;
                        r_stop_idx <= 1'b0;
                        r_serial   <= START_BIT;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= (^tx_data_in) ^ 1'(PARITY_ODD);
`endif
                    end
                end

                START: begin
                    if (w_tick) begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_state  <= DATA;
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (r_idx == C_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_serial <= r_parity;
                            r_state  <= PARITY;
`else
                            r_serial <= STOP_BIT;
                            r_state  <= STOP;
`endif
                        end else begin
                            r_serial <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_idx    <= r_idx + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_serial <= STOP_BIT;
                        r_state  <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (r_stop_idx == C_STOP_LAST && w_cnt == C_CNT_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_stop_idx == C_STOP_LAST) begin
                            r_serial <= LINE_IDLE;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_serial <= LINE_IDLE;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign tx_serial = r_serial;
    assign tx_ready  = r_ready;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Three instances with
//                CLKS_PER_BIT=4: #0 even parity/1 stop, #1 odd parity/2 stops,
//                #2 odd parity/1 stop. Expected line waveforms come from a
//                frame-builder model (bit list expanded to cycles).
//                Honours UART_TX_PARITY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    int         sel;

    always #5 clk = ~clk;

    logic v0, v1, v2;
    logic s0, s1, s2, r0, r1, r2, b0, b1, b2, d0, d1, d2;
    logic o_serial, o_ready, o_busy, o_done;

    assign v0 = tx_valid && (sel == 0);
    assign v1 = tx_valid && (sel == 1);
    assign v2 = tx_valid && (sel == 2);

    assign o_serial = (sel == 0) ? s0 : ((sel == 1) ? s1 : s2);
    assign o_ready  = (sel == 0) ? r0 : ((sel == 1) ? r1 : r2);
    assign o_busy   = (sel == 0) ? b0 : ((sel == 1) ? b1 : b2);
    assign o_done   = (sel == 0) ? d0 : ((sel == 1) ? d1 : d2);

    uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .t_clk(clk), .t_rst(rst), .tx_valid(v0), .tx_data_in(tx_data),
        .tx_ready(r0), .tx_serial(s0), .tx_busy(b0), .tx_done(d0));

    uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
        .t_clk(clk), .t_rst(rst), .tx_valid(v1), .tx_data_in(tx_data),
        .tx_ready(r1), .tx_serial(s1), .tx_busy(b1), .tx_done(d1));

    uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY_ODD(1)) u_dut2 (
        .t_clk(clk), .t_rst(rst), .tx_valid(v2), .tx_data_in(tx_data),
        .tx_ready(r2), .tx_serial(s2), .tx_busy(b2), .tx_done(d2));

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    logic obs[0:63];

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         exp_len;
        logic       exp_tail;   // line value of the bit right after the data bits
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: frame = start, data LSB first, [parity], stop bits; each bit
    // lasts N cycles.
    task automatic build_expected(input logic [7:0] d, input int s);
        logic bits[$];
        int   stops;
        int   odd;
        stops = (s == 1) ? 2 : 1;
        odd   = (s == 0) ? 0 : 1;
        bits.delete();
        bits.push_back(1'b0);
        for (int k = 0; k < DW; k++) bits.push_back(d[k]);
        if (PB == 1) bits.push_back((^d) ^ odd[0]);
        for (int k = 0; k < stops; k++) bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[b]) for (int r = 0; r < N; r++) exp_q.push_back(bits[b]);
    endtask

    // Caller has tx_valid=1 / tx_data=d set at a negedge with the DUT idle.
    task automatic expect_frame(input logic [7:0] d, input bit keep_valid,
                                input logic [7:0] next_d, output int done_at);
        int f;
        build_expected(d, sel);
        f       = exp_q.size();
        done_at = -1;
        for (int i = 0; i < f; i++) begin
            @(negedge clk);
            obs[i] = o_serial;
            chk($sformatf("serial[%0d] data=%02h dut=%0d", i + 1, d, sel), o_serial, exp_q[i]);
            chk($sformatf("busy[%0d]", i + 1), o_busy, 1);
            chk($sformatf("ready[%0d]", i + 1), o_ready, 0);
            chk($sformatf("done[%0d]", i + 1), o_done, (i == f - 1));
            if (o_done === 1'b1 && done_at < 0) done_at = i + 1;
            if (i == 0) tx_data = next_d;
            else if (!keep_valid) tx_data = 8'($urandom);
            if (!keep_valid) tx_valid = (i == f - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, " idle serial"}, o_serial, 1);
        chk({tag, " idle ready"}, o_ready, 1);
        chk({tag, " idle busy"}, o_busy, 0);
        chk({tag, " idle done"}, o_done, 0);
    endtask

    function automatic logic [7:0] decode();
        logic [7:0] v;
        for (int k = 0; k < DW; k++) v[k] = obs[(k + 1) * N + N / 2];
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         done_at;
        logic [0:9] dd_line;
        logic [7:0] d;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sel      = 0;

        vecs[0] = '{0, 8'hDD, 40 + 4 * PB, (PB == 1) ? 1'b0 : 1'b1};
        vecs[1] = '{0, 8'h07, 40 + 4 * PB, 1'b1};
        vecs[2] = '{2, 8'h07, 40 + 4 * PB, (PB == 1) ? 1'b0 : 1'b1};
        vecs[3] = '{1, 8'hF0, 44 + 4 * PB, 1'b1};
        vecs[4] = '{1, 8'h00, 44 + 4 * PB, 1'b1};
        vecs[5] = '{2, 8'h80, 40 + 4 * PB, (PB == 1) ? 1'b0 : 1'b1};
        vecs[6] = '{0, 8'hFF, 40 + 4 * PB, (PB == 1) ? 1'b0 : 1'b1};
        dd_line = (PB == 1) ? 10'b0101110110 : 10'b0101110111;

        // Reset state of every instance
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset serial dut%0d", s), o_serial, 1);
            chk($sformatf("reset ready dut%0d", s), o_ready, 1);
            chk($sformatf("reset busy dut%0d", s), o_busy, 0);
            chk($sformatf("reset done dut%0d", s), o_done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 0;

        // Directed table; data input is forced to 00 after acceptance
        for (int vi = 0; vi < 7; vi++) begin
            sel      = vecs[vi].sel;
            tx_data  = vecs[vi].data;
            tx_valid = 1'b1;
            expect_frame(vecs[vi].data, 1'b0, 8'h00, done_at);
            chk($sformatf("done cycle vec%0d", vi), done_at, vecs[vi].exp_len);
            chk($sformatf("tail bit vec%0d", vi), obs[(DW + 1) * N + 1], vecs[vi].exp_tail);
            chk($sformatf("decode vec%0d", vi), decode(), vecs[vi].data);
            if (vi == 0) begin
                for (int b = 0; b < 10; b++)
                    for (int r = 0; r < N; r++)
                        chk($sformatf("DD line bit%0d cyc%0d", b, r), obs[b * N + r], dd_line[b]);
            end
            idle_check($sformatf("vec%0d", vi));
        end

        // Back-to-back with tx_valid held high: 55 then AA
        sel      = 0;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        expect_frame(8'h55, 1'b1, 8'hAA, done_at);
        chk("b2b first done cycle", done_at, 40 + 4 * PB);
        chk("b2b first decode", decode(), 8'h55);
        idle_check("b2b gap");
        expect_frame(8'hAA, 1'b0, 8'hAA, done_at);
        chk("b2b second done cycle", done_at, 40 + 4 * PB);
        chk("b2b second decode", decode(), 8'hAA);
        idle_check("b2b end");

        // Reset during data bit 3 (A5 has bit3 = 0)
        sel      = 0;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
        chk("bit3 before reset", o_serial, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset serial", o_serial, 1);
        chk("midreset ready", o_ready, 1);
        chk("midreset busy", o_busy, 0);
        chk("midreset done", o_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post reset ready", o_ready, 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk($sformatf("abandoned frame no done %0d", i), o_done, 0);
            chk($sformatf("idle line high %0d", i), o_serial, 1);
        end

        // Randomized frames with idle gaps and mid-frame input noise
        for (int it = 0; it < 30; it++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle_check($sformatf("rnd gap %0d", it));
            sel      = $urandom_range(0, 2);
            d        = 8'($urandom);
            tx_data  = d;
            tx_valid = 1'b1;
            expect_frame(d, 1'b0, 8'($urandom), done_at);
            chk($sformatf("rnd done cycle %0d", it), done_at, ((sel == 1) ? 44 : 40) + 4 * PB);
            idle_check($sformatf("rnd end %0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the payload bits per frame.
REQ-003 Parameter CLKS_PER_BIT, default 16, SHALL set the t_clk cycles per serial bit; legal range is >= 2.
REQ-004 Parameter STOP_BITS, default 1, SHALL set the stop bit count; legal values are 1 and 2.
REQ-005 Parameter PARITY_ODD, default 0, SHALL select the parity sense (0 = even, 1 = odd); it takes effect only when UART_TX_PARITY_EN is defined.
REQ-006 Port t_clk, input, 1 bit, SHALL be the transmit clock.
REQ-007 Port t_rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-008 Port tx_valid, input, 1 bit, SHALL mean a byte is offered on tx_data_in.
REQ-009 Port tx_data_in, input, DATA_WIDTH bits, SHALL carry the payload.
REQ-010 Port tx_ready, output, 1 bit, SHALL mean the block can accept a byte.
REQ-011 Port tx_serial, output, 1 bit, SHALL be the serial line; it idles high.
REQ-012 Port tx_busy, output, 1 bit, SHALL be high while a frame is in progress.
REQ-013 Port tx_done, output, 1 bit, SHALL be a one-cycle pulse marking frame completion.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; PARITY exists only when the macro is enabled.
REQ-015 tx_ready SHALL be 1 only in IDLE; acceptance SHALL occur on an edge where tx_valid && tx_ready.
REQ-016 On acceptance, tx_data_in SHALL be latched into a shift register, and tx_serial SHALL drive 0 (START) from the next cycle.
REQ-017 Each bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a counter that runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-018 Data bits SHALL be sent LSB first; a bit index counter SHALL run 0..DATA_WIDTH-1, and DATA SHALL exit when the index is DATA_WIDTH-1 and the counter wraps.
REQ-019 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done SHALL pulse on the last STOP cycle; the FSM SHALL then return to IDLE.
REQ-020 Back-to-back frames SHALL be separated by exactly one IDLE cycle, during which tx_serial = 1.
REQ-021 tx_busy SHALL be 1 in every state except IDLE.
REQ-022 Changes to tx_data_in or tx_valid during a frame SHALL have no effect on that frame.
REQ-023 With tx_valid low in IDLE, tx_serial SHALL stay 1 indefinitely.
REQ-024 tx_serial SHALL be driven from a flop, with no combinational path from any input.

Reset
REQ-025 While t_rst = 1: FSM = IDLE, counters = 0, shift register = 0, tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
REQ-026 Reset mid-frame SHALL abandon the frame; tx_serial SHALL be 1 from the first edge with reset high, and no tx_done SHALL be emitted for that frame.

Configuration
REQ-027 With UART_TX_PARITY_EN defined, one parity bit SHALL follow the last data bit for CLKS_PER_BIT cycles, with value XOR(data) ^ PARITY_ODD.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-029 Package uart_pkg SHALL hold the typedef tx_state_t, constants LINE_IDLE = 1, START_BIT = 0 and STOP_BIT = 1, and the default CLKS_PER_BIT.
REQ-030 Sub-module uart_baud_gen SHALL provide the bit-period counter and a bit_tick pulse; all other logic SHALL reside in uart_tx.

Verification
REQ-031 DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, no parity, send 8'hDD accepted at edge 0 -> line 0,1,0,1,1,1,0,1,1,1, each for 4 cycles over cycles 1..40; tx_done at cycle 40.
REQ-032 tx_valid held high with 8'h55 then 8'hAA -> second acceptance exactly 41 cycles after the first, and both frames decode correctly.
REQ-033 UART_TX_PARITY_EN defined, 8'h07: PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; tx_done at cycle 44.
REQ-034 Reset asserted during data bit 3 -> tx_serial = 1 on the next edge, tx_ready = 1 after release, no tx_done for that frame.
REQ-035 tx_data_in changed to 8'h00 mid-frame after accepting 8'hF0 -> line carries 8'hF0.
REQ-036 STOP_BITS=2 -> line high for 8 cycles after the last data bit before tx_done; frame length 44 cycles.
